// File: rtl/mdr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdr_pkg : shared types and helpers for the MDR sequencer                   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package mdr_pkg;

  localparam int c_NUM_UNITS = 3;

  typedef enum logic [1:0] {
    OP_MUL     = 2'd0,
    OP_DIV     = 2'd1,
    OP_SQRT    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // SQRT retires two radicand bits per iteration, so it needs half the steps.
  function automatic int iter_len(op_e op, int word_length);
    return (op == OP_SQRT) ? word_length / 2 : word_length;
  endfunction

  function automatic logic [c_NUM_UNITS-1:0] op_onehot(op_e op);
    case (op)
      OP_MUL:  return 3'b001;
      OP_DIV:  return 3'b010;
      OP_SQRT: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdr_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdr_sequencer_if : request, unit and result signals of the MDR sequencer   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface mdr_sequencer_if #(
  parameter int WORD_LENGTH = 16,
  parameter int CNT_WIDTH   = 5
);
  logic                     start;
  logic [1:0]               op;
  logic [WORD_LENGTH-1:0]   operand_x;
  logic [WORD_LENGTH-1:0]   operand_y;
  logic                     unit_load;
  logic [2:0]               unit_enable;
  logic [CNT_WIDTH-1:0]     iter_count;
  logic [3*WORD_LENGTH-1:0] unit_p1;
  logic [3*WORD_LENGTH-1:0] unit_p2;
  logic [2:0]               unit_sel;
  logic [WORD_LENGTH-1:0]   partial_sum;
  logic [3*WORD_LENGTH-1:0] unit_result;
  logic [3*WORD_LENGTH-1:0] unit_residue;
  logic [WORD_LENGTH-1:0]   result;
  logic [WORD_LENGTH-1:0]   residue;
  logic                     busy;
  logic                     done;
  logic                     error;

  modport master (
    output start, op, operand_x, operand_y,
    output unit_p1, unit_p2, unit_sel, unit_result, unit_residue,
    input  unit_load, unit_enable, iter_count, partial_sum,
    input  result, residue, busy, done, error
  );

  modport slave (
    input  start, op, operand_x, operand_y,
    input  unit_p1, unit_p2, unit_sel, unit_result, unit_residue,
    output unit_load, unit_enable, iter_count, partial_sum,
    output result, residue, busy, done, error
  );
endinterface
`default_nettype wire

// File: rtl/mdr_shared_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdr_shared_adder : operand mux and add/sub time-shared by the MDR units    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module mdr_shared_adder
  import mdr_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic                               i_active,
  input  op_e                                i_op,
  input  logic [c_NUM_UNITS*WORD_LENGTH-1:0] i_p1,
  input  logic [c_NUM_UNITS*WORD_LENGTH-1:0] i_p2,
  input  logic [c_NUM_UNITS-1:0]             i_sel,
  output logic [WORD_LENGTH-1:0]             o_sum
);

  logic [WORD_LENGTH-1:0] w_a;
  logic [WORD_LENGTH-1:0] w_b;
  logic                   w_add;
  logic                   w_valid;

  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_add   = 1'b1;
    w_valid = 1'b0;
    case (i_op)
      OP_MUL: begin
        w_a     = i_p1[0 +: WORD_LENGTH];
        w_b     = i_p2[0 +: WORD_LENGTH];
        w_add   = i_sel[0];
        w_valid = 1'b1;
      end
      OP_DIV: begin
        w_a     = i_p1[WORD_LENGTH +: WORD_LENGTH];
        w_b     = i_p2[WORD_LENGTH +: WORD_LENGTH];
        w_add   = i_sel[1];
        w_valid = 1'b1;
      end
      OP_SQRT: begin
        w_a     = i_p1[2*WORD_LENGTH +: WORD_LENGTH];
        w_b     = i_p2[2*WORD_LENGTH +: WORD_LENGTH];
        w_add   = i_sel[2];
        w_valid = 1'b1;
      end
      default: ;
    endcase

    if (i_active && w_valid)
      o_sum = w_add ? (w_a + w_b) : (w_a - w_b);
    else
      o_sum = '0;
  end

endmodule
`default_nettype wire

// File: rtl/mdr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdr_sequencer : loads/iterates MUL, DIV, SQRT units and captures results   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module mdr_sequencer
  import mdr_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic           clk,
  input  logic           reset,
  mdr_sequencer_if.slave bus
);

  state_e                 r_state;
  op_e                    r_op;
  logic [WORD_LENGTH-1:0] r_x;
  logic [WORD_LENGTH-1:0] r_y;
  logic [WORD_LENGTH-1:0] r_result;
  logic [WORD_LENGTH-1:0] r_residue;
  logic [CNT_WIDTH-1:0]   r_iter;
  logic [2:0]             r_enable;
  logic                   r_load;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  op_e                    w_req_op;
  logic [CNT_WIDTH-1:0]   w_iter_init;
  logic [WORD_LENGTH-1:0] w_sum;
  logic [WORD_LENGTH-1:0] w_sel_result;
  logic [WORD_LENGTH-1:0] w_sel_residue;

  assign w_req_op    = op_e'(bus.op);
  assign w_iter_init = CNT_WIDTH'(iter_len(w_req_op, WORD_LENGTH) - 1);

  always_comb begin
    w_sel_result  = '0;
    w_sel_residue = '0;
    case (r_op)
      OP_MUL: begin
        w_sel_result = bus.unit_result[0 +: WORD_LENGTH];
      end
      OP_DIV: begin
        w_sel_result  = bus.unit_result[WORD_LENGTH +: WORD_LENGTH];
        w_sel_residue = bus.unit_residue[WORD_LENGTH +: WORD_LENGTH];
      end
      OP_SQRT: begin
        w_sel_result  = bus.unit_result[2*WORD_LENGTH +: WORD_LENGTH];
        w_sel_residue = bus.unit_residue[2*WORD_LENGTH +: WORD_LENGTH];
      end
      default: ;
    endcase
  end

  mdr_shared_adder #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_adder (
    .i_active (r_state != IDLE),
    .i_op     (r_op),
    .i_p1     (bus.unit_p1),
    .i_p2     (bus.unit_p2),
    .i_sel    (bus.unit_sel),
    .o_sum    (w_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_op      <= OP_MUL;
      r_x       <= '0;
      r_y       <= '0;
      r_result  <= '0;
      r_residue <= '0;
      r_iter    <= '0;
      r_enable  <= '0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= w_req_op;
            r_x     <= bus.operand_x;
            r_y     <= bus.operand_y;
            r_iter  <= w_iter_init;
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // Rejected requests skip the units entirely and report straight away.
          if (r_op == OP_ILLEGAL) begin
            r_result  <= '0;
            r_residue <= '0;
            r_error   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_iter    <= '0;
            r_state   <= DONE;
          end else if (r_op == OP_DIV && r_y == '0) begin
            r_result  <= '1;
            r_residue <= r_x;
            r_error   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_iter    <= '0;
            r_state   <= DONE;
          end else begin
            r_enable <= op_onehot(r_op);
            r_state  <= RUN;
          end
        end
        RUN: begin
          if (r_iter == '0)
            r_state <= FIX;
          else
            r_iter <= r_iter - 1'b1;
        end
        FIX: begin
          r_enable  <= '0;
          r_result  <= w_sel_result;
          r_residue <= (r_op == OP_MUL) ? '0 : w_sel_residue;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.unit_load   = r_load;
  assign bus.unit_enable = r_enable;
  assign bus.iter_count  = r_iter;
  assign bus.partial_sum = w_sum;
  assign bus.result      = r_result;
  assign bus.residue     = r_residue;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mdr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mdr_sequencer : random and directed checks with iterative unit models   |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mdr_sequencer;

  localparam int W = 16;
  localparam int C = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  mdr_sequencer_if #(.WORD_LENGTH(W), .CNT_WIDTH(C)) bus ();

  mdr_sequencer #(.WORD_LENGTH(W), .CNT_WIDTH(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit-serial units that borrow the sequencer's adder for every step.
  logic [15:0] m_acc, m_x, m_y;
  logic [15:0] d_rem, d_q, d_x, d_y;
  logic [15:0] s_rem, s_root, s_x;
  int          m_step, d_step, s_step;
  logic [3:0]  ii;
  logic [2:0]  si;
  logic [15:0] m_p1, m_p2, d_rs, s_rs, s_trial;

  assign ii      = bus.iter_count[3:0];
  assign si      = bus.iter_count[2:0];
  assign m_p1    = {m_acc[14:0], 1'b0};
  assign m_p2    = m_y[ii] ? m_x : 16'h0;
  assign d_rs    = {d_rem[14:0], d_x[ii]};
  assign s_rs    = {s_rem[13:0], s_x[{si, 1'b1}], s_x[{si, 1'b0}]};
  assign s_trial = {s_root[13:0], 2'b01};

  assign bus.unit_p1      = {s_rs, d_rs, m_p1};
  assign bus.unit_p2      = {s_trial, d_y, m_p2};
  assign bus.unit_sel     = 3'b001;
  assign bus.unit_result  = {s_root, d_q, m_acc};
  assign bus.unit_residue = {s_rem, d_rem, 16'h0};

  always @(posedge clk) begin
    if (bus.unit_load) begin
      m_acc <= '0; m_x <= bus.operand_x; m_y <= bus.operand_y; m_step <= 0;
      d_rem <= '0; d_q <= '0; d_x <= bus.operand_x; d_y <= bus.operand_y; d_step <= 0;
      s_rem <= '0; s_root <= '0; s_x <= bus.operand_x; s_step <= 0;
    end else begin
      if (bus.unit_enable[0]) begin
        if (m_step < W) m_acc <= bus.partial_sum;
        m_step <= m_step + 1;
      end
      if (bus.unit_enable[1]) begin
        if (d_step < W) begin
          if (d_rs >= d_y) begin
            d_rem <= bus.partial_sum;
            d_q   <= {d_q[14:0], 1'b1};
          end else begin
            d_rem <= d_rs;
            d_q   <= {d_q[14:0], 1'b0};
          end
        end
        d_step <= d_step + 1;
      end
      if (bus.unit_enable[2]) begin
        if (s_step < W / 2) begin
          if (s_rs >= s_trial) begin
            s_rem  <= bus.partial_sum;
            s_root <= {s_root[14:0], 1'b1};
          end else begin
            s_rem  <= s_rs;
            s_root <= {s_root[14:0], 1'b0};
          end
        end
        s_step <= s_step + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic [15:0] rd, output logic e,
                       output int lat, output int n);
    logic [31:0] p;
    int q;
    n = (op == 2'd2) ? W / 2 : W;
    e = 1'b0;
    r = '0;
    rd = '0;
    case (op)
      2'd0: begin
        p = 32'(x) * 32'(y);
        r = p[15:0];
      end
      2'd1: begin
        if (y == 16'd0) begin
          r = 16'hFFFF; rd = x; e = 1'b1;
        end else begin
          r = x / y; rd = x % y;
        end
      end
      2'd2: begin
        q = 0;
        while ((q + 1) * (q + 1) <= int'(x)) q++;
        r = 16'(q);
        rd = 16'(int'(x) - q * q);
      end
      default: e = 1'b1;
    endcase
    lat = e ? 2 : 3 + n;
  endtask

  // Issues one request (start is raised at the current negedge) and follows it to done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] x,
                        input logic [15:0] y, input int exp_wait, input int pulse_k,
                        input int chg_k);
    logic [15:0] er, erd;
    logic        ee;
    logic [2:0]  oh;
    int          lat, n, k, waitc, en_hit, en_any;
    bit          got_done, busy_ok;
    model(op, x, y, er, erd, ee, lat, n);
    oh = (op == 2'd3) ? 3'b000 : 3'(1 << op);
    bus.op = op; bus.operand_x = x; bus.operand_y = y; bus.start = 1'b1;
    waitc = 0;
    do begin
      @(posedge clk); @(negedge clk); waitc++;
    end while (!bus.unit_load && waitc < 10);
    bus.start = 1'b0;
    check({tag, ".accept"}, bus.unit_load, 1'b1);
    if (!bus.unit_load) return;
    if (exp_wait != 0) check({tag, ".accept_wait"}, waitc, exp_wait);
    check({tag, ".busy_load"}, bus.busy, 1'b1);
    check({tag, ".err_clr"}, bus.error, 1'b0);
    check({tag, ".iter_init"}, bus.iter_count, n - 1);
    k = 1; en_hit = 0; en_any = 0; got_done = 0; busy_ok = 1;
    while (1) begin
      if (bus.unit_enable != 3'b000) en_any++;
      if (bus.unit_enable == oh) en_hit++;
      if (bus.done) begin
        got_done = 1;
        break;
      end
      if (!bus.busy) busy_ok = 0;
      if (pulse_k != 0 && k == pulse_k) bus.start = 1'b1;
      if (pulse_k != 0 && k == pulse_k + 1) bus.start = 1'b0;
      if (chg_k != 0 && k == chg_k) begin
        bus.operand_x = 16'($urandom);
        bus.operand_y = 16'($urandom);
      end
      if (k >= 40) break;
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, got_done, 1'b1);
    check({tag, ".latency"}, k, lat);
    check({tag, ".result"}, bus.result, er);
    check({tag, ".residue"}, bus.residue, erd);
    check({tag, ".error"}, bus.error, ee);
    check({tag, ".busy_done"}, bus.busy, 1'b0);
    check({tag, ".busy_held"}, busy_ok, 1'b1);
    check({tag, ".en_cycles"}, en_any, ee ? 0 : n + 1);
    if (!ee) check({tag, ".en_onehot"}, en_hit, n + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.operand_x = '0; bus.operand_y = '0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {bus.unit_enable, bus.unit_load, bus.busy, bus.done, bus.error,
                            bus.result, bus.residue, bus.iter_count}, 64'h0);
    check("reset.psum", bus.partial_sum, 16'h0);
    reset = 1'b1;
    @(negedge clk);

    run_op("sqrt100",  2'd2, 16'd100,   16'd0,   1, 0, 0);
    run_op("sqrt255",  2'd2, 16'd255,   16'd0,   2, 0, 0);
    run_op("mul300",   2'd0, 16'd300,   16'd200, 2, 0, 0);
    run_op("div1000",  2'd1, 16'd1000,  16'd7,   2, 0, 0);
    run_op("div0",     2'd1, 16'd5,     16'd0,   2, 0, 0);
    run_op("illegal",  2'd3, 16'd77,    16'd9,   2, 0, 0);
    run_op("after_il", 2'd0, 16'hFFFF,  16'hFFFF, 2, 0, 0);
    run_op("midrun",   2'd1, 16'd50000, 16'd123, 2, 4, 6);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [15:0] rx, ry;
      rop = 2'($urandom_range(0, 3));
      rx  = 16'($urandom);
      if (rop == 2'd1)
        ry = (i % 6 == 0) ? 16'd0 : 16'($urandom_range(1, 32767));
      else
        ry = 16'($urandom);
      run_op("rand", rop, rx, ry, 2, 0, 0);
    end

    @(negedge clk);
    check("idle.psum", bus.partial_sum, 16'h0);
    check("idle.done", bus.done, 1'b0);

    // Abort a SQRT in the middle of its iterations.
    bus.op = 2'd2; bus.operand_x = 16'd200; bus.operand_y = 16'd0; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.iter", bus.iter_count, 5'd4);
    reset = 1'b0;
    #1;
    check("abort.outputs", {bus.unit_enable, bus.unit_load, bus.busy, bus.done, bus.error,
                            bus.result, bus.residue, bus.iter_count}, 64'h0);
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("abort.no_done", saw_done, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    run_op("sqrt144", 2'd2, 16'd144, 16'd0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
- Top-level controller for the multiply/divide/square-root (MDR) block.
- Accepts one operation request at a time and loads and enables the selected iterative unit (MUL, DIV, SQRT) for the required number of iterations.
- Owns the single add/subtract resource that the units time-share: each unit presents its two partial operands and an add/sub select, and the sequencer returns the sum.
- Captures the final result and residue, then pulses done.

Parameters:
- WORD_LENGTH, 16, operand/result width; must be even, at least 4.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2^CNT_WIDTH > WORD_LENGTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe, sampled only in IDLE
- op  in  2  00=MUL, 01=DIV, 10=SQRT, 11=illegal
- operand_x  in  WORD_LENGTH  multiplicand / dividend / radicand
- operand_y  in  WORD_LENGTH  multiplier / divisor; ignored for SQRT
- unit_load  out  1  one-cycle clear/load strobe to the selected unit
- unit_enable  out  3  one-hot iteration enable {SQRT,DIV,MUL}
- iter_count  out  CNT_WIDTH  current iteration index, counting down to 0
- unit_p1  in  3*WORD_LENGTH  partial operand A per unit, packed [MUL,DIV,SQRT] low to high
- unit_p2  in  3*WORD_LENGTH  partial operand B per unit
- unit_sel  in  3  per unit: 1 = add, 0 = subtract
- partial_sum  out  WORD_LENGTH  shared adder output, broadcast to all units
- unit_result  in  3*WORD_LENGTH  per-unit result
- unit_residue  in  3*WORD_LENGTH  per-unit remainder/residue
- result  out  WORD_LENGTH  registered final result
- residue  out  WORD_LENGTH  registered final remainder; 0 for MUL
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, result/residue valid
- error  out  1  sticky until next accepted start: divide-by-zero or illegal op

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - All outputs go to 0: unit_enable, unit_load, busy, done, error, result, residue, iter_count.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE -> LOAD when start=1.
  - op, operand_x and operand_y are latched.
  - busy rises in the next cycle.
  - error clears.
- LOAD (1 cycle):
  - unit_load=1 to the selected unit.
  - iter_count = N-1, where N = WORD_LENGTH for MUL/DIV and WORD_LENGTH/2 for SQRT.
  - If op=11, or op=DIV with operand_y==0: go directly to DONE with error=1.
    - DIV-by-zero: result = all-ones, residue = operand_x.
    - Illegal op: result = 0, residue = 0.
  - Otherwise go to RUN.
- RUN (N cycles):
  - unit_enable is the one-hot of the latched op.
  - iter_count decrements each cycle; at iter_count==0, go to FIX.
- FIX (1 cycle):
  - unit_enable stays asserted for the residue-correction step: SQRT/DIV restore a negative remainder via the adder; MUL passes through.
  - At the end of FIX, result and residue are registered from the selected unit's slices.
- DONE (1 cycle): done=1, busy=0 in this same cycle; then go to IDLE.
- Latency:
  - start sampled at edge t0; done high during cycle t0+3+N.
  - MUL/DIV (W=16): 19 cycles. SQRT: 11 cycles. Error cases: 2 cycles.
- Shared adder (combinational):
  - Operands are selected from the unit indicated by the latched op.
  - partial_sum = sel ? p1+p2 : p1-p2, modulo 2^WORD_LENGTH.
  - In IDLE, partial_sum = 0.
- start outside IDLE is ignored; there is no queueing.
- start held high continuously starts back-to-back operations, one per 4+N cycles.
- Operand changes after acceptance have no effect.
- result/residue hold their value until the next FIX or error DONE.
- All arithmetic is unsigned.

Decomposition:
- Shared package mdr_pkg:
  - op_e enum: OP_MUL, OP_DIV, OP_SQRT, OP_ILLEGAL.
  - state_e enum: IDLE, LOAD, RUN, FIX, DONE.
  - Function iter_len(op, WORD_LENGTH).
- One natural sub-module: mdr_shared_adder, the combinational operand mux plus add/sub.
- FSM, counter and capture registers stay in mdr_sequencer.

Test Plan:
- SQRT, operand_x=100, with reference SQRT unit attached -> done at start+11 cycles, result=10, residue=0, error=0; unit_enable=100b for exactly 9 cycles.
- SQRT, operand_x=255 -> result=15, residue=30; then MUL 300*200 issued at the done cycle -> result=60000, residue=0, done at +19.
- DIV 1000/7 -> result=142, residue=6; DIV 5/0 -> done at start+2, error=1, result=16'hFFFF, residue=5, unit_enable never asserted.
- op=11 -> done at start+2, error=1, result=0; the next valid start clears error in the cycle after acceptance.
- start pulsed during RUN, and operand_x changed mid-RUN -> ignored; results match the original operands; busy stays high until done.
- reset driven low mid-RUN (iteration 4 of SQRT) -> all outputs 0 immediately, no done; after release, a fresh SQRT 144 -> result=12.
